// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding, default framing constants and line levels
package uart_pkg;
  localparam int OSR_DEF = 16;
  localparam int NB_DEF = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
`endif
endpackage

// File: rtl/rx_sync.sv
// rx_sync: two-flop synchronizer for the serial line, resets to idle-high
module rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) {q, m} <= 2'b11;
    else {q, m} <= {m, d};
endmodule

// File: rtl/register_rx.sv
// register_rx: oversampled UART receiver; define RX_PARITY_EN to add an even-parity bit and parity_err_o
module register_rx import uart_pkg::*; #(
  parameter int OSR = OSR_DEF,
  parameter int NB = NB_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clk_os,
  input  logic          rx_i,
  output logic [NB-1:0] data_o,
  output logic          valid_o,
  output logic          frame_err_o,
`ifdef RX_PARITY_EN
  output logic          parity_err_o,
`endif
  output logic          busy_o
);
  localparam int CW = $clog2(OSR);
  localparam int BW = $clog2(NB + 1);
`ifdef RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = PARITY;
  logic par, par_n, perr_n;
`else
  localparam rx_state_t AFTER_DATA = STOP;
`endif
  rx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bits, bits_n;
  logic [NB-1:0] sh, sh_n, data_n;
  logic rx_s, wrap, valid_n, ferr_n;
  rx_sync u_sync (.clk_i(clk_i), .rst_i(rst_i), .d(rx_i), .q(rx_s));
  assign wrap = cnt == CW'(OSR - 1);
  assign busy_o = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    bits_n = bits;
    sh_n = sh;
    data_n = data_o;
    valid_n = 1'b0;
    ferr_n = 1'b0;
`ifdef RX_PARITY_EN
    par_n = par;
    perr_n = 1'b0;
`endif
    if (clk_os) begin
      cnt_n = wrap ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt_n = '0;
          if (rx_s == START_BIT) state_n = START;
        end
        START: if (cnt == CW'(OSR / 2 - 1)) begin
          cnt_n = '0;
          bits_n = '0;
          state_n = rx_s == START_BIT ? DATA : IDLE;
        end
        DATA: if (wrap) begin
          sh_n = {rx_s, sh[NB-1:1]};
          bits_n = bits + 1'b1;
          if (bits == BW'(NB - 1)) state_n = AFTER_DATA;
        end
`ifdef RX_PARITY_EN
        PARITY: if (wrap) begin
          par_n = rx_s;
          state_n = STOP;
        end
`endif
        STOP: if (wrap) begin
          data_n = sh;
          valid_n = rx_s == STOP_BIT;
          ferr_n = rx_s != STOP_BIT;
`ifdef RX_PARITY_EN
          perr_n = (rx_s == STOP_BIT) && (^{sh, par});
`endif
          state_n = rx_s == STOP_BIT ? IDLE : BREAK;
        end
        BREAK: if (rx_s == STOP_BIT) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state <= IDLE;
      cnt <= '0;
      bits <= '0;
      sh <= '0;
      data_o <= '0;
      valid_o <= 1'b0;
      frame_err_o <= 1'b0;
`ifdef RX_PARITY_EN
      par <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bits <= bits_n;
      sh <= sh_n;
      data_o <= data_n;
      valid_o <= valid_n;
      frame_err_o <= ferr_n;
`ifdef RX_PARITY_EN
      par <= par_n;
      parity_err_o <= perr_n;
`endif
    end
endmodule

// File: tb/tb_register_rx.sv
// tb_register_rx: directed self-checking bench for register_rx
module tb_register_rx;
  localparam int OSR = 16;
  localparam int NB = 8;
`ifdef RX_PARITY_EN
  localparam int FB = NB + 3;
`else
  localparam int FB = NB + 2;
`endif
  localparam int STOP_TK = OSR / 2 + 1 + OSR * (FB - 1);
  logic clk = 1'b0, rst_n = 1'b0, clk_os = 1'b0, rx = 1'b1, os_en = 1'b1;
  logic [NB-1:0] data;
  logic valid, ferr, busy;
  int div = 0, tk = 0, both = 0, n_cmp = 0, n_bad = 0;
  int vq[$], fq[$];
`ifdef RX_PARITY_EN
  logic perr, pflip = 1'b0;
  int pq[$];
`endif
  register_rx #(.OSR(OSR), .NB(NB)) dut (
    .clk_i(clk), .rst_i(rst_n), .clk_os(clk_os), .rx_i(rx),
    .data_o(data), .valid_o(valid), .frame_err_o(ferr),
`ifdef RX_PARITY_EN
    .parity_err_o(perr),
`endif
    .busy_o(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    div = (div + 1) % 4;
    clk_os = os_en && div == 0;
  end
  always @(posedge clk) if (clk_os) tk <= tk + 1;
  always @(negedge clk) begin
    if (valid) vq.push_back(tk);
    if (ferr) fq.push_back(tk);
    if (valid && ferr) both <= both + 1;
`ifdef RX_PARITY_EN
    if (perr) pq.push_back(valid ? tk : -1);
`endif
  end
  task automatic tick;
    @(posedge clk);
    while (!clk_os) @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n);
    repeat (n) tick();
  endtask
  task automatic clear_q;
    vq.delete();
    fq.delete();
`ifdef RX_PARITY_EN
    pq.delete();
`endif
  endtask
  task automatic send_frame(input logic [7:0] d, input logic sb, input bit frz, output int t0);
    logic [FB-1:0] fr;
`ifdef RX_PARITY_EN
    fr = {sb, ^d ^ pflip, d, 1'b0};
`else
    fr = {sb, d, 1'b0};
`endif
    t0 = tk;
    for (int i = 0; i < FB; i++) begin
      rx = fr[i];
      if (frz && i == 4) begin
        os_en = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        os_en = 1'b1;
      end
      ticks(OSR);
    end
  endtask
  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_cmp += 4;
    if (data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", data); end
    if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", valid); end
    if (ferr !== 1'b0) begin n_bad++; $display("FAIL reset_ferr got %b want 0", ferr); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    ticks(4);
  endtask
  task automatic test_clean;
    int t0, vt;
    clear_q();
    send_frame(8'hA5, 1'b1, 1'b0, t0);
    rx = 1'b1;
    ticks(8);
    vt = vq.size() > 0 ? vq[0] : -1;
    n_cmp += 5;
    if (vq.size() !== 1) begin n_bad++; $display("FAIL clean_pulses got %0d want 1", vq.size()); end
    if (vt !== t0 + STOP_TK) begin n_bad++; $display("FAIL clean_latency got tick %0d want %0d", vt, t0 + STOP_TK); end
    if (data !== 8'hA5) begin n_bad++; $display("FAIL clean_data got %h want a5", data); end
    if (fq.size() !== 0) begin n_bad++; $display("FAIL clean_ferr got %0d want 0", fq.size()); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL clean_busy got %b want 0", busy); end
  endtask
  task automatic test_glitch;
    clear_q();
    rx = 1'b0;
    ticks(2);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_high got %b want 1", busy); end
    ticks(3);
    rx = 1'b1;
    ticks(20);
    n_cmp += 4;
    if (vq.size() !== 0) begin n_bad++; $display("FAIL glitch_valid got %0d want 0", vq.size()); end
    if (fq.size() !== 0) begin n_bad++; $display("FAIL glitch_ferr got %0d want 0", fq.size()); end
    if (data !== 8'hA5) begin n_bad++; $display("FAIL glitch_data got %h want a5", data); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_idle got %b want 0", busy); end
  endtask
  task automatic test_frame_err;
    int t0, ft;
    clear_q();
    send_frame(8'h3C, 1'b0, 1'b0, t0);
    ticks(40);
    ft = fq.size() > 0 ? fq[0] : -1;
    n_cmp += 5;
    if (fq.size() !== 1) begin n_bad++; $display("FAIL ferr_pulses got %0d want 1", fq.size()); end
    if (ft !== t0 + STOP_TK) begin n_bad++; $display("FAIL ferr_tick got %0d want %0d", ft, t0 + STOP_TK); end
    if (vq.size() !== 0) begin n_bad++; $display("FAIL ferr_valid got %0d want 0", vq.size()); end
    if (data !== 8'h3C) begin n_bad++; $display("FAIL ferr_data got %h want 3c", data); end
    if (busy !== 1'b1) begin n_bad++; $display("FAIL ferr_break got %b want 1", busy); end
    rx = 1'b1;
    ticks(20);
    n_cmp += 2;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL break_exit got %b want 0", busy); end
    if (vq.size() !== 0) begin n_bad++; $display("FAIL break_start got %0d want 0", vq.size()); end
    send_frame(8'h55, 1'b1, 1'b0, t0);
    rx = 1'b1;
    ticks(8);
    n_cmp += 3;
    if (vq.size() !== 1) begin n_bad++; $display("FAIL after_break_valid got %0d want 1", vq.size()); end
    if (data !== 8'h55) begin n_bad++; $display("FAIL after_break_data got %h want 55", data); end
    if (fq.size() !== 1) begin n_bad++; $display("FAIL after_break_ferr got %0d want 1", fq.size()); end
  endtask
  task automatic test_back_to_back;
    int t0, t1, v0, v1;
    clear_q();
    send_frame(8'h00, 1'b1, 1'b0, t0);
    send_frame(8'hFF, 1'b1, 1'b0, t1);
    rx = 1'b1;
    ticks(8);
    v0 = vq.size() > 0 ? vq[0] : -1;
    v1 = vq.size() > 1 ? vq[1] : -1;
    n_cmp += 4;
    if (vq.size() !== 2) begin n_bad++; $display("FAIL b2b_pulses got %0d want 2", vq.size()); end
    if (v0 !== t0 + STOP_TK) begin n_bad++; $display("FAIL b2b_first got %0d want %0d", v0, t0 + STOP_TK); end
    if (v1 - v0 !== OSR * FB) begin n_bad++; $display("FAIL b2b_spacing got %0d want %0d", v1 - v0, OSR * FB); end
    if (data !== 8'hFF) begin n_bad++; $display("FAIL b2b_data got %h want ff", data); end
  endtask
  task automatic test_reset_mid;
    int t0;
    logic [9:0] fr;
    clear_q();
    fr = {1'b1, 8'h81, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = fr[i];
      ticks(i == 4 ? OSR / 2 : OSR);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (data !== 8'h00) begin n_bad++; $display("FAIL rstmid_data got %h want 00", data); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
    if (valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b want 0", valid); end
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    ticks(20);
    n_cmp += 2;
    if (vq.size() + fq.size() !== 0) begin n_bad++; $display("FAIL rstmid_pulse got %0d want 0", vq.size() + fq.size()); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle got %b want 0", busy); end
    send_frame(8'h81, 1'b1, 1'b0, t0);
    rx = 1'b1;
    ticks(8);
    n_cmp += 2;
    if (vq.size() !== 1) begin n_bad++; $display("FAIL rstmid_next_valid got %0d want 1", vq.size()); end
    if (data !== 8'h81) begin n_bad++; $display("FAIL rstmid_next_data got %h want 81", data); end
  endtask
  task automatic test_freeze;
    int t0, vt;
    clear_q();
    send_frame(8'h5A, 1'b1, 1'b1, t0);
    rx = 1'b1;
    ticks(8);
    vt = vq.size() > 0 ? vq[0] : -1;
    n_cmp += 3;
    if (vq.size() !== 1) begin n_bad++; $display("FAIL freeze_pulses got %0d want 1", vq.size()); end
    if (vt !== t0 + STOP_TK) begin n_bad++; $display("FAIL freeze_tick got %0d want %0d", vt, t0 + STOP_TK); end
    if (data !== 8'h5A) begin n_bad++; $display("FAIL freeze_data got %h want 5a", data); end
  endtask
`ifdef RX_PARITY_EN
  task automatic test_parity;
    int t0, vt, pt;
    clear_q();
    pflip = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0, t0);
    rx = 1'b1;
    ticks(8);
    vt = vq.size() > 0 ? vq[0] : -2;
    pt = pq.size() > 0 ? pq[0] : -3;
    n_cmp += 3;
    if (vq.size() !== 1) begin n_bad++; $display("FAIL par_bad_valid got %0d want 1", vq.size()); end
    if (pt !== vt) begin n_bad++; $display("FAIL par_bad_perr got tick %0d want %0d", pt, vt); end
    if (data !== 8'h07) begin n_bad++; $display("FAIL par_bad_data got %h want 07", data); end
    clear_q();
    pflip = 1'b0;
    send_frame(8'h07, 1'b1, 1'b0, t0);
    rx = 1'b1;
    ticks(8);
    n_cmp += 2;
    if (vq.size() !== 1) begin n_bad++; $display("FAIL par_ok_valid got %0d want 1", vq.size()); end
    if (pq.size() !== 0) begin n_bad++; $display("FAIL par_ok_perr got %0d want 0", pq.size()); end
  endtask
`endif
  initial begin
    test_reset();
    test_clean();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_freeze();
`ifdef RX_PARITY_EN
    test_parity();
`endif
    n_cmp++;
    if (both !== 0) begin n_bad++; $display("FAIL valid_and_ferr got %0d cycles want 0", both); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/register_rx.md
REGISTER_RX -- requirements
Module: register_rx

Interface
REQ-001 SHALL have parameter OSR, default 16, the number of clk_os ticks per bit (must be even and at least 8).
REQ-002 SHALL have parameter NB, default 8, the number of data bits per frame.
REQ-003 SHALL have port clk_i, input, 1 bit, the single system clock; all flops are rising-edge clk_i.
REQ-004 SHALL have port rst_i, input, 1 bit, the reset: asynchronous and active-low.
REQ-005 SHALL have port clk_os, input, 1 bit, an oversample enable that is high for one clk_i cycle, at OSR x baud.
REQ-006 SHALL have port rx_i, input, 1 bit, the serial line (idle high; start 0, NB data LSB first, [parity], stop 1).
REQ-007 SHALL have port data_o, output, NB bits, the last received byte.
REQ-008 SHALL have port valid_o, output, 1 bit, a one-cycle pulse when data_o updates with a good frame.
REQ-009 SHALL have port frame_err_o, output, 1 bit, a one-cycle pulse when the stop bit is sampled 0.
REQ-010 SHALL have port busy_o, output, 1 bit, high in any state other than IDLE.

Function
REQ-011 SHALL pass rx_i through a 2-flop synchronizer, reset to 1; all logic uses the synchronized rx_s only.
REQ-012 SHALL have states IDLE, START, DATA, PARITY (macro only), STOP and BREAK.
REQ-013 SHALL keep a tick counter that advances only on clk_os and wraps at OSR-1; sampling happens only on clk_os cycles.
REQ-014 SHALL, in IDLE, clear the counter and move to START on the first clk_os with rx_s=0.
REQ-015 SHALL, in START, re-sample at counter OSR/2-1 (mid-bit): if 0, clear the counter and go to DATA; if 1, treat it as a glitch and return to IDLE with no pulse.
REQ-016 SHALL, in DATA, sample at each counter wrap (OSR ticks apart, mid-bit), shift right into the MSB, and leave DATA after NB samples.
REQ-017 SHALL, in STOP, sample at wrap:
- rx_s=1: load data_o, pulse valid_o, go to IDLE.
- rx_s=0: load data_o, pulse frame_err_o, go to BREAK.
REQ-018 SHALL, in BREAK, stay until rx_s=1 on a clk_os cycle, then go to IDLE; no start is detected while in BREAK.
REQ-019 SHALL have latency from the stop-bit mid-sample clk_os cycle to valid_o equal to exactly 1 clk_i cycle.
REQ-020 SHALL never assert valid_o and frame_err_o in the same cycle.
REQ-021 SHALL hold data_o between frames; a glitch in START leaves data_o unchanged.
REQ-022 SHALL have no effect when clk_os is held low: state, counter and outputs freeze except the synchronizer.
REQ-023 SHALL accept a start edge arriving in the same clk_os tick as the IDLE return: a back-to-back frame is detected with no lost bit.

Reset
REQ-024 SHALL, on rst_i=0, force immediately: state IDLE, counter 0, shift register 0, data_o 0, valid_o 0, frame_err_o 0, busy_o 0, synchronizer 1.
REQ-025 SHALL, on reset mid-frame, discard the partial frame with no pulse; reception restarts on the next falling edge after release.

Configuration
REQ-026 SHALL, with macro RX_PARITY_EN defined:
- add state PARITY between DATA and STOP, with one mid-bit sample;
- add output parity_err_o (1 bit, reset 0), pulsed together with valid_o when the even parity of the data and parity bits is 1;
- leave data_o loaded.
REQ-027 SHALL, without RX_PARITY_EN, have no PARITY state, no parity_err_o port, and a frame of 1+NB+1 bits.

Structure
REQ-028 SHALL place in shared package uart_pkg: the rx_state_t enum, the default OSR/NB constants and the STOP_BIT/START_BIT constants.
REQ-029 SHALL put the synchronizer in sub-module rx_sync (2 flops, asynchronous active-low reset to 1), instantiated once.

Verification
REQ-030 SHALL cover a frame 0xA5 at OSR=16, clean: data_o=0xA5, a single valid_o pulse, 1 cycle after the stop mid-sample, busy_o low afterwards.
REQ-031 SHALL cover a 0 glitch lasting 5 clk_os ticks on an idle line: no pulse, data_o unchanged, back in IDLE.
REQ-032 SHALL cover 0x3C with the stop bit forced 0, then the line held low 40 ticks: a single frame_err_o pulse, data_o=0x3C, no start detected until the line rises, after which the next frame 0x55 gives valid_o.
REQ-033 SHALL cover 0x00 followed by 0xFF back-to-back with zero idle: two valid_o pulses, 160 ticks apart.
REQ-034 SHALL cover rst_i low during data bit 4 of 0x81: outputs 0 at once, no pulse; a following 0x81 is received correctly.
REQ-035 SHALL cover, with RX_PARITY_EN, 0x07 sent with parity bit 0: valid_o together with parity_err_o; sent with parity bit 1: valid_o only.
